// File: rtl/cc_pkg.sv
// Shared constants, FSM state type and identity-matrix helper for the colour-correction coefficient path.
package cc_pkg;
  localparam int CC_NUM_COEFF       = 9;
  localparam int CC_BYTES_PER_COEFF = 2;
  localparam int CC_NUM_BYTES       = CC_NUM_COEFF * CC_BYTES_PER_COEFF;
  localparam int CC_MAX_W           = 16;

  typedef logic [CC_NUM_COEFF-1:0][CC_MAX_W-1:0] cc_wide_bank_t;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, PENDING} cc_load_state_t;

  // Built at the widest supported coefficient width; users truncate to their own width.
  function automatic cc_wide_bank_t cc_identity(input int frac_bits);
    cc_wide_bank_t bank;
    bank = '0;
    for (int k = 0; k < CC_NUM_COEFF; k += 4)
      bank[k] = CC_MAX_W'(1) << frac_bits;
    return bank;
  endfunction
endpackage

// File: rtl/cc_coeff_loader_if.sv
// Byte-serial coefficient write stream between the host/control path and cc_coeff_loader.
interface cc_coeff_loader_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_sop;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, output wr_sop, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, input  wr_sop, output wr_ready);
endinterface

// File: rtl/cc_shadow_bank.sv
// 18-byte shadow coefficient store: byte-addressed writes, whole-bank packed read.
module cc_shadow_bank
  import cc_pkg::*;
#(
  parameter int COEFF_W   = 12,
  parameter int FRAC_BITS = 6
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 we,
  input  logic [4:0]                           addr,
  input  logic [7:0]                           wdata,
  output logic [CC_NUM_COEFF-1:0][COEFF_W-1:0] bank
);
  localparam int            HI_W  = COEFF_W - 8;
  localparam cc_wide_bank_t IDENT = cc_identity(FRAC_BITS);

  // Odd (high) bytes keep only the bits that belong to the coefficient.
  logic [7:0]      lo_q [CC_NUM_COEFF];
  logic [HI_W-1:0] hi_q [CC_NUM_COEFF];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < CC_NUM_COEFF; k++) begin
        lo_q[k] <= IDENT[k][7:0];
        hi_q[k] <= IDENT[k][COEFF_W-1:8];
      end
    end else if (we) begin
      if (addr[0]) hi_q[addr[4:1]] <= wdata[HI_W-1:0];
      else         lo_q[addr[4:1]] <= wdata;
    end
  end

  always_comb begin
    for (int k = 0; k < CC_NUM_COEFF; k++)
      bank[k] = {hi_q[k], lo_q[k]};
  end
endmodule

// File: rtl/cc_coeff_loader.sv
// Assembles a byte-serial 3x3 colour-correction matrix into a shadow bank and commits it at frame start.
// Optional trailing XOR checksum byte enabled by defining CC_COEFF_LOADER_CHECKSUM_EN.
module cc_coeff_loader
  import cc_pkg::*;
#(
  parameter  int INT_BITS  = 6,
  parameter  int FRAC_BITS = 6,
  localparam int COEFF_W   = INT_BITS + FRAC_BITS
) (
  input  logic                                        clk,
  input  logic                                        reset,
  cc_coeff_loader_if.slave                            wr,
  input  logic                                        frame_start,
  output logic signed [CC_NUM_COEFF-1:0][COEFF_W-1:0] cc_coeff,
  output logic                                        load_pending,
  output logic                                        commit,
  output logic                                        load_err
);
  typedef logic [CC_NUM_COEFF-1:0][COEFF_W-1:0] bank_t;

  function automatic bank_t identity_bank();
    cc_wide_bank_t wide;
    bank_t         b;
    wide = cc_identity(FRAC_BITS);
    for (int k = 0; k < CC_NUM_COEFF; k++)
      b[k] = wide[k][COEFF_W-1:0];
    return b;
  endfunction

  localparam bank_t IDENT = identity_bank();

`ifdef CC_COEFF_LOADER_CHECKSUM_EN
  localparam logic [4:0] LAST_BYTE = 5'(CC_NUM_BYTES);
`else
  localparam logic [4:0] LAST_BYTE = 5'(CC_NUM_BYTES - 1);
`endif

  cc_load_state_t state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           wr_ready_q;
  logic           accept;
  logic           commit_d;
  logic           shadow_we;
  logic [4:0]     shadow_addr;
  bank_t          shadow_bank;
`ifdef CC_COEFF_LOADER_CHECKSUM_EN
  logic [7:0]     xor_q, xor_d;
  logic           chk_ok_q, chk_ok_d;
`endif

  assign accept      = wr.wr_valid && wr_ready_q;
  assign wr.wr_ready = wr_ready_q;

  cc_shadow_bank #(
    .COEFF_W   (COEFF_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_shadow (
    .clk   (clk),
    .reset (reset),
    .we    (shadow_we),
    .addr  (shadow_addr),
    .wdata (wr.wr_data),
    .bank  (shadow_bank)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_we   = 1'b0;
    shadow_addr = cnt_q;
    commit_d    = 1'b0;
`ifdef CC_COEFF_LOADER_CHECKSUM_EN
    xor_d       = xor_q;
    chk_ok_d    = chk_ok_q;
`endif
    case (state_q)
      IDLE, LOAD: begin
        // sop always restarts at byte 0; non-sop bytes in IDLE are swallowed.
        if (accept && wr.wr_sop) begin
          shadow_we   = 1'b1;
          shadow_addr = '0;
          cnt_d       = 5'd1;
          state_d     = LOAD;
`ifdef CC_COEFF_LOADER_CHECKSUM_EN
          xor_d       = wr.wr_data;
`endif
        end else if (accept && (state_q == LOAD)) begin
          shadow_we = (cnt_q < 5'(CC_NUM_BYTES));
          cnt_d     = cnt_q + 5'd1;
`ifdef CC_COEFF_LOADER_CHECKSUM_EN
          xor_d     = xor_q ^ wr.wr_data;
`endif
          if (cnt_q == LAST_BYTE) begin
            cnt_d = cnt_q;
`ifdef CC_COEFF_LOADER_CHECKSUM_EN
            chk_ok_d = (xor_q == wr.wr_data);
            state_d  = CHECK;
`else
            state_d  = PENDING;
`endif
          end
        end
      end
`ifdef CC_COEFF_LOADER_CHECKSUM_EN
      CHECK:   state_d = chk_ok_q ? PENDING : IDLE;
`else
      CHECK:   state_d = IDLE;
`endif
      PENDING: begin
        if (frame_start) begin
          commit_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      wr_ready_q   <= 1'b0;
      load_pending <= 1'b0;
      commit       <= 1'b0;
      cc_coeff     <= IDENT;
    end else begin
      cnt_q        <= cnt_d;
      wr_ready_q   <= (state_d == IDLE) || (state_d == LOAD);
      load_pending <= (state_d == PENDING);
      commit       <= commit_d;
      if (commit_d) cc_coeff <= shadow_bank;
    end
  end

`ifdef CC_COEFF_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xor_q    <= '0;
      chk_ok_q <= 1'b0;
      load_err <= 1'b0;
    end else begin
      xor_q    <= xor_d;
      chk_ok_q <= chk_ok_d;
      load_err <= (state_q == CHECK) && !chk_ok_q;
    end
  end
`else
  assign load_err = 1'b0;
`endif
endmodule

// File: tb/tb_cc_coeff_loader.sv
// Bench for cc_coeff_loader: randomized coefficient packets checked against a bank-level reference model.
module tb_cc_coeff_loader;
  localparam int W = 12;
`ifdef CC_COEFF_LOADER_CHECKSUM_EN
  localparam int PKT_LEN = 19;
`else
  localparam int PKT_LEN = 18;
`endif

  typedef logic [8:0][W-1:0] bank_t;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  logic  frame_start = 1'b0;
  bank_t cc_coeff;
  logic  load_pending, commit, load_err;
  int    checks = 0;
  int    failures = 0;
  int    err_cnt = 0;
  bank_t model_active;
`ifdef CC_COEFF_LOADER_CHECKSUM_EN
  logic [7:0] csum_flip = 8'h00;
`endif

  cc_coeff_loader_if wr();

  cc_coeff_loader u_dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .frame_start  (frame_start),
    .cc_coeff     (cc_coeff),
    .load_pending (load_pending),
    .commit       (commit),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load_err === 1'b1) err_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic bank_t ident();
    bank_t b;
    b = '0;
    b[0] = 12'd64;
    b[4] = 12'd64;
    b[8] = 12'd64;
    return b;
  endfunction

  function automatic bank_t fill(input logic [W-1:0] v);
    bank_t b;
    for (int k = 0; k < 9; k++) b[k] = v;
    return b;
  endfunction

  function automatic bank_t rand_bank();
    bank_t b;
    for (int k = 0; k < 9; k++) b[k] = W'($urandom);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sop, input logic fs, input int gap);
    logic rdy;
    int   n;
    repeat (gap) tick();
    wr.wr_valid = 1'b1;
    wr.wr_data  = d;
    wr.wr_sop   = sop;
    frame_start = fs;
    n = 0;
    do begin
      @(negedge clk);
      rdy = wr.wr_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 50);
    #1;
    wr.wr_valid = 1'b0;
    wr.wr_sop   = 1'b0;
    frame_start = 1'b0;
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL byte_accept timeout: wr_ready=%b required 1", wr.wr_ready);
    end
  endtask

  // Low byte, then high bits with random junk above the coefficient width.
  task automatic send_packet(input bank_t c, input bit gaps, input bit fs_last);
    logic [7:0] b[$];
    for (int k = 0; k < 9; k++) begin
      b.push_back(c[k][7:0]);
      b.push_back({4'($urandom), c[k][11:8]});
    end
`ifdef CC_COEFF_LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (b[i]) x ^= b[i];
      b.push_back(x ^ csum_flip);
    end
`endif
    for (int i = 0; i < b.size(); i++)
      send_byte(b[i], i == 0, fs_last && (i == b.size() - 1), gaps ? int'($urandom_range(0, 2)) : 0);
`ifdef CC_COEFF_LOADER_CHECKSUM_EN
    tick();
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wr.wr_ready, load_pending, commit, load_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: ready/pend/commit/err=%b required 0000",
               {wr.wr_ready, load_pending, commit, load_err});
    end
    reset = 1'b1;
    tick();
    checks++;
    if (wr.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: wr_ready=%b required 1", wr.wr_ready);
    end
    checks++;
    if (cc_coeff !== ident()) begin
      failures++;
      $display("FAIL reset_identity: cc_coeff=%h required %h", cc_coeff, ident());
    end
    model_active = ident();
  endtask

  task automatic test_commit_neg1();
    bank_t c;
    c = fill(12'hFC0);
    send_packet(c, 1'b0, 1'b0);
    checks++;
    if (load_pending !== 1'b1 || wr.wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL neg1_pending: load_pending=%b wr_ready=%b required 1 0", load_pending, wr.wr_ready);
    end
    checks++;
    if (cc_coeff !== model_active) begin
      failures++;
      $display("FAIL neg1_early: cc_coeff=%h required %h", cc_coeff, model_active);
    end
    pulse_frame();
    checks++;
    if (cc_coeff !== c) begin
      failures++;
      $display("FAIL neg1_commit_value: cc_coeff=%h required %h", cc_coeff, c);
    end
    checks++;
    if (commit !== 1'b1 || load_pending !== 1'b0) begin
      failures++;
      $display("FAIL neg1_commit_flags: commit=%b load_pending=%b required 1 0", commit, load_pending);
    end
    model_active = c;
    tick();
    checks++;
    if (commit !== 1'b0) begin
      failures++;
      $display("FAIL neg1_commit_width: commit=%b required 0", commit);
    end
  endtask

  task automatic test_frame_with_last_byte();
    bank_t c;
    int    n;
    c = rand_bank();
    send_packet(c, 1'b0, 1'b1);
    checks++;
    if (commit !== 1'b0 || cc_coeff !== model_active) begin
      failures++;
      $display("FAIL lastbyte_no_commit: commit=%b cc_coeff=%h required 0 %h", commit, cc_coeff, model_active);
    end
    n = $urandom_range(2, 5);
    wr.wr_valid = 1'b1;
    wr.wr_sop   = 1'b1;
    wr.wr_data  = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (wr.wr_ready !== 1'b0 || load_pending !== 1'b1 || commit !== 1'b0) begin
        failures++;
        $display("FAIL pending_hold: wr_ready=%b load_pending=%b commit=%b required 0 1 0",
                 wr.wr_ready, load_pending, commit);
      end
      tick();
    end
    wr.wr_valid = 1'b0;
    wr.wr_sop   = 1'b0;
    pulse_frame();
    checks++;
    if (cc_coeff !== c || commit !== 1'b1) begin
      failures++;
      $display("FAIL lastbyte_late_commit: cc_coeff=%h commit=%b required %h 1", cc_coeff, commit, c);
    end
    model_active = c;
    tick();
    checks++;
    if (wr.wr_ready !== 1'b1 || load_pending !== 1'b0) begin
      failures++;
      $display("FAIL lastbyte_idle: wr_ready=%b load_pending=%b required 1 0", wr.wr_ready, load_pending);
    end
  endtask

  task automatic test_restart();
    bank_t c;
    int    e0;
    e0 = err_cnt;
    send_byte(8'($urandom), 1'b1, 1'b0, 0);
    for (int i = 1; i < 10; i++) send_byte(8'($urandom), 1'b0, 1'b0, 0);
    c = fill(12'h040);
    send_packet(c, 1'b0, 1'b0);
    checks++;
    if (load_pending !== 1'b1) begin
      failures++;
      $display("FAIL restart_pending: load_pending=%b required 1", load_pending);
    end
    pulse_frame();
    checks++;
    if (cc_coeff !== c || commit !== 1'b1) begin
      failures++;
      $display("FAIL restart_commit: cc_coeff=%h commit=%b required %h 1", cc_coeff, commit, c);
    end
    model_active = c;
    tick();
    checks++;
    if (err_cnt != e0) begin
      failures++;
      $display("FAIL restart_no_err: load_err pulses=%0d required 0", err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'($urandom), 1'b1, 1'b0, 0);
    for (int i = 1; i < 7; i++) send_byte(8'($urandom), 1'b0, 1'b0, 0);
    wr.wr_valid = 1'b1;
    wr.wr_sop   = 1'b0;
    wr.wr_data  = 8'($urandom);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (cc_coeff !== ident()) begin
      failures++;
      $display("FAIL midreset_identity: cc_coeff=%h required %h", cc_coeff, ident());
    end
    checks++;
    if (wr.wr_ready !== 1'b0 || load_pending !== 1'b0) begin
      failures++;
      $display("FAIL midreset_ctrl: wr_ready=%b load_pending=%b required 0 0", wr.wr_ready, load_pending);
    end
    wr.wr_valid = 1'b0;
    tick();
    reset = 1'b1;
    model_active = ident();
    tick();
    for (int i = 0; i < PKT_LEN; i++) send_byte(8'($urandom), 1'b0, 1'b0, 0);
    tick();
    checks++;
    if (load_pending !== 1'b0 || wr.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_drop: load_pending=%b wr_ready=%b required 0 1", load_pending, wr.wr_ready);
    end
    pulse_frame();
    checks++;
    if (cc_coeff !== model_active || commit !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_commit: cc_coeff=%h commit=%b required %h 0", cc_coeff, commit, model_active);
    end
  endtask

  task automatic test_random();
    bank_t c;
    for (int it = 0; it < 5; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        pulse_frame();
        checks++;
        if (commit !== 1'b0 || cc_coeff !== model_active) begin
          failures++;
          $display("FAIL rand_idle_frame: commit=%b cc_coeff=%h required 0 %h", commit, cc_coeff, model_active);
        end
      end
      c = rand_bank();
      send_packet(c, 1'b1, 1'b0);
      checks++;
      if (load_pending !== 1'b1 || cc_coeff !== model_active) begin
        failures++;
        $display("FAIL rand_pending: load_pending=%b cc_coeff=%h required 1 %h", load_pending, cc_coeff, model_active);
      end
      pulse_frame();
      checks++;
      if (cc_coeff !== c || commit !== 1'b1) begin
        failures++;
        $display("FAIL rand_commit: cc_coeff=%h commit=%b required %h 1", cc_coeff, commit, c);
      end
      model_active = c;
      tick();
    end
  endtask

`ifdef CC_COEFF_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bank_t c;
    int    e0;
    e0 = err_cnt;
    c = rand_bank();
    csum_flip = 8'h01;
    send_packet(c, 1'b0, 1'b0);
    csum_flip = 8'h00;
    tick();
    tick();
    checks++;
    if (err_cnt != e0 + 1) begin
      failures++;
      $display("FAIL csum_err_pulse: load_err pulses=%0d required 1", err_cnt - e0);
    end
    checks++;
    if (load_pending !== 1'b0 || wr.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL csum_idle: load_pending=%b wr_ready=%b required 0 1", load_pending, wr.wr_ready);
    end
    pulse_frame();
    checks++;
    if (cc_coeff !== model_active || commit !== 1'b0) begin
      failures++;
      $display("FAIL csum_no_commit: cc_coeff=%h commit=%b required %h 0", cc_coeff, commit, model_active);
    end
    c = rand_bank();
    send_packet(c, 1'b1, 1'b0);
    pulse_frame();
    checks++;
    if (cc_coeff !== c || commit !== 1'b1) begin
      failures++;
      $display("FAIL csum_good_commit: cc_coeff=%h commit=%b required %h 1", cc_coeff, commit, c);
    end
    model_active = c;
    tick();
  endtask
`endif

  initial begin
    wr.wr_valid = 1'b0;
    wr.wr_data  = 8'h00;
    wr.wr_sop   = 1'b0;
    test_reset();
    test_commit_neg1();
    test_frame_with_last_byte();
    test_restart();
    test_reset_mid();
    test_random();
`ifdef CC_COEFF_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cc_coeff_loader.md
Name: cc_coeff_loader

Overview:
- Writer side of the `cc_coeff` interface consumed by the colour-correction matrix stage.
- Accepts a byte-serial coefficient stream from the host/control path and assembles nine signed fixed-point coefficients into a shadow bank.
- Commits the shadow bank to the active `cc_coeff` output only at a frame boundary, so a frame never mixes two matrices.

Parameters:
- INT_BITS, 6, integer bits per coefficient (including sign)
- FRAC_BITS, 6, fractional bits per coefficient
- COEFF_W, INT_BITS+FRAC_BITS, coefficient width (derived; not overridden)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wr_valid  in  1  byte-stream valid
- wr_data  in  8  byte-stream data
- wr_sop  in  1  start of packet; qualified by wr_valid
- wr_ready  out  1  loader can accept a byte
- frame_start  in  1  single-cycle pulse at start of each frame
- cc_coeff  out  9×COEFF_W  active signed coefficient array; index k is element k, packed [8:0][COEFF_W-1:0]
- load_pending  out  1  full shadow bank waiting for commit
- commit  out  1  one-cycle pulse when the active bank is updated
- load_err  out  1  one-cycle pulse on a rejected packet

Behaviour:
- Reset (reset=0, asynchronous):
  - cc_coeff = identity: elements 0, 4 and 8 = 1<<FRAC_BITS (64); all others 0.
  - Shadow bank is cleared to the same identity values.
  - wr_ready=0, load_pending=0, commit=0, load_err=0.
  - FSM enters IDLE.
  - Reset during a load discards the partial packet; the active bank returns to identity.
- Byte transfer: a byte is taken when wr_valid && wr_ready on a rising clk edge.
- Packet format: 18 bytes. Coefficient k (k=0..8) is sent as byte 2k = bits[7:0] and byte 2k+1 = bits[COEFF_W-1:8]. Byte-2k+1 bits above COEFF_W-9 are ignored.
- FSM states:
  - IDLE: wr_ready=1. A transfer with wr_sop=1 stores byte 0, sets byte_cnt=1 and moves to LOAD. A transfer with wr_sop=0 is accepted and dropped.
  - LOAD: wr_ready=1. Each transfer writes the shadow byte at byte_cnt and increments byte_cnt.
    - A transfer with wr_sop=1 in LOAD restarts: the byte is stored as byte 0 and byte_cnt=1. The shadow bank keeps stale values until overwritten. No error is flagged.
    - When byte 17 is accepted: go to PENDING (or CHECK with the macro).
  - PENDING: wr_ready=0, load_pending=1. On frame_start: copy shadow to cc_coeff at that edge, pulse commit the next cycle, go to IDLE.
- Commit latency: cc_coeff updates on the same clk edge that samples frame_start=1 in PENDING. commit is high for the following cycle.
- Simultaneous events:
  - frame_start in the same cycle as the final byte does not commit; the load commits at the next frame_start.
  - frame_start in IDLE or LOAD has no effect.
- cc_coeff changes only on commit or reset; it is never partially updated.
- byte_cnt is 5 bits and never wraps; reaching 17 forces the state exit.

Optional Feature:
- Macro: CC_COEFF_LOADER_CHECKSUM_EN.
- Defined:
  - A packet is 19 bytes; byte 18 is the XOR of bytes 0..17.
  - After byte 18 is accepted, the FSM spends one cycle in CHECK (wr_ready=0).
  - Match: go to PENDING.
  - Mismatch: pulse load_err for one cycle, return to IDLE, leave load_pending=0. cc_coeff is unchanged and the shadow bank is not committed.
- Undefined: no CHECK state; packet is 18 bytes; load_err is tied to 0.

Decomposition:
- Shared package cc_pkg:
  - constants CC_NUM_COEFF=9, CC_BYTES_PER_COEFF=2
  - function cc_identity(frac_bits) returning the packed identity array
  - FSM state enum typedef cc_load_state_t {IDLE, LOAD, CHECK, PENDING}
- Sub-module cc_shadow_bank: 18-byte addressable shadow register with byte write-enable and parallel packed read. Instantiated once.
- The FSM, counter and commit register stay in cc_coeff_loader.

Test Plan:
- Reset release, no traffic → cc_coeff[0]=cc_coeff[4]=cc_coeff[8]=64, all others 0; wr_ready=1 one cycle after reset deasserts.
- Send 18 bytes encoding all coefficients = 12'hFC0 (−1.0), then a frame_start pulse → load_pending=1 after the last byte; cc_coeff all 12'hFC0 at the frame_start edge; commit high for 1 cycle; load_pending=0.
- Last byte and frame_start in the same cycle → no commit; next frame_start commits; wr_ready=0 for the whole of PENDING.
- Send 10 bytes, then wr_sop with a new 18-byte packet of coefficient 12'h040 → the committed bank is all 12'h040; no load_err.
- Assert reset mid-packet (byte 7) → cc_coeff = identity; after release, a byte with wr_sop=0 is dropped and the FSM stays in IDLE.
- Checksum build: correct XOR → normal commit. Corrupt byte 18 by 8'h01 → load_err pulses once, load_pending stays 0, cc_coeff unchanged across the following frame_start.
